piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter that drives the single-bit serial line feeding our `WireToReg` shift-register chains. It accepts one WIDTH-bit word through a valid/ready handshake and shifts it out LSB first, one bit per clock, with a frame strobe. After WIDTH clocks of shifting, the receiving chain's taps hold the whole word.

---
 rtl/piso_serializer.sv | 126 ++++++++++++
 tb/tb_piso_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word per handshake,
// sent LSB first with a frame strobe; optional even parity bit.
//
// Ports:
//   CLK, RST_n  : clock (rising edge), asynchronous active-low reset
//   load_valid  : load_data holds a word to send
//   load_data   : WIDTH-bit word, sampled only on the accept edge
//   load_ready  : registered; high while a word can be accepted
//   ser_out     : registered serial data, LSB first
//   ser_frame   : registered; high while ser_out carries a frame bit
//   done        : registered one-cycle pulse on the last frame bit
//
// Build option: define PISO_PARITY_EN to append an even-parity bit
// after the data bits (frame length WIDTH+1, done on the parity bit).

module piso_serializer #(
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef PISO_PARITY_EN
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    // Holds the bits still to be sent; bit 0 is the next one out,
    // since bit 0 of the word goes straight to ser_out on accept.
    logic [WIDTH-1:0] sreg;
`ifdef PISO_PARITY_EN
    logic             par;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            load_ready <= 1'b0;
            ser_out    <= 1'b0;
            ser_frame  <= 1'b0;
            done       <= 1'b0;
`ifdef PISO_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Ready comes up one edge after reset release.
                    load_ready <= 1'b1;
                    ser_out    <= 1'b0;
                    ser_frame  <= 1'b0;
                    done       <= 1'b0;
                    if (load_valid && load_ready) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        sreg       <= load_data >> 1;
                        ser_out    <= load_data[0];
                        ser_frame  <= 1'b1;
                        load_ready <= 1'b0;
`ifdef PISO_PARITY_EN
                        par        <= ^load_data;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        cnt     <= cnt + 1'b1;
                        sreg    <= sreg >> 1;
                        ser_out <= sreg[0];
`ifndef PISO_PARITY_EN
                        // Raise done together with the final data bit.
                        done    <= (cnt == PENULT);
`endif
                    end else begin
`ifdef PISO_PARITY_EN
                        state      <= PARITY;
                        ser_out    <= par;
                        done       <= 1'b1;
`else
                        state      <= IDLE;
                        ser_out    <= 1'b0;
                        ser_frame  <= 1'b0;
                        done       <= 1'b0;
                        load_ready <= 1'b1;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state      <= IDLE;
                    ser_out    <= 1'b0;
                    ser_frame  <= 1'b0;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                end
`endif
                default: begin
                    state      <= IDLE;
                    ser_out    <= 1'b0;
                    ser_frame  <= 1'b0;
                    done       <= 1'b0;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: a frame-level model predicts
// accepts, ready timing and the serial bit stream of every word.

module tb_piso_serializer;

    localparam int W = 5;
`ifdef PISO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         CLK;
    logic         RST_n;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         ser_out;
    logic         ser_frame;
    logic         done;

    piso_serializer #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_frame  (ser_frame),
        .done       (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d",
                     name, $time, act, exp);
        end
    endtask

    // Reference model: a word is taken whenever the block is free and
    // valid is high; it is then busy for FRAME cycles, after which it
    // is ready again (giving one idle cycle before the next frame).
    logic [W-1:0] q[$];
    bit           mready = 1'b0;
    int           busy = 0;
    int           n_acc = 0;

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            mready = 1'b0;
            busy   = 0;
            q.delete();
        end else if (mready && load_valid) begin
            q.push_back(load_data);
            n_acc++;
            mready = 1'b0;
            busy   = FRAME;
        end else if (busy > 0) begin
            busy--;
            mready = (busy == 0);
        end else begin
            mready = 1'b1;
        end
    end

    // Monitor: pops the expected word once its frame has ended.
    int           idx = 0;
    logic [W-1:0] w;
    logic         ebit;

    always @(negedge CLK) begin
        if (!RST_n) begin
            idx = 0;
            chk("reset_outputs", int'({load_ready, ser_out, ser_frame, done}), 0);
        end else begin
            chk("load_ready", int'(load_ready), int'(mready));
            if (ser_frame) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    w    = q[0];
                    ebit = (idx < W) ? w[idx] : ^w;
                    chk($sformatf("ser_out_bit%0d", idx), int'(ser_out), int'(ebit));
                    chk($sformatf("done_bit%0d", idx), int'(done),
                        (idx == FRAME - 1) ? 1 : 0);
                    idx++;
                end
            end else begin
                chk("idle_ser_out", int'(ser_out), 0);
                chk("idle_done", int'(done), 0);
                if (idx != 0) begin
                    chk("frame_len", idx, FRAME);
                    void'(q.pop_front());
                    idx = 0;
                end
            end
        end
    end

    // Present a word until the model has taken it (bounded wait).
    task automatic send(input logic [W-1:0] d, input bit keep);
        int c;
        bit ok;
        c  = n_acc;
        ok = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (n_acc != c) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", int'(ok), 1);
        if (!keep) load_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (3) @(negedge CLK);
        RST_n = 1'b1;
        repeat (4) @(negedge CLK);

        send(5'b10110, 1'b0);
        repeat (8) @(negedge CLK);

        // Busy rejection: valid stays high with a new word mid-frame.
        send(5'b00001, 1'b1);
        load_data = 5'b11111;
        send(5'b11111, 1'b0);
        repeat (8) @(negedge CLK);

        send(5'b00011, 1'b1);
        send(5'b11000, 1'b0);
        repeat (8) @(negedge CLK);

        send(5'b10010, 1'b0);
        repeat (8) @(negedge CLK);

        // Reset during cycle 2 of a frame.
        send(5'b01101, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #2 RST_n = 1'b0;
        #1;
        chk("async_rst_ser_out", int'(ser_out), 0);
        chk("async_rst_frame", int'(ser_frame), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_ready", int'(load_ready), 0);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        repeat (2) @(negedge CLK);
        send(5'b01011, 1'b0);
        repeat (8) @(negedge CLK);

        for (int i = 0; i < 300; i++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = W'($urandom);
            @(negedge CLK);
        end
        load_valid = 1'b0;
        repeat (FRAME + 4) @(negedge CLK);

        chk("queue_drained", q.size(), 0);
        chk("no_open_frame", idx, 0);
        chk("accept_count_min", int'(n_acc > 8), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
